// File: rtl/bayer_pkg.sv
// Shared types and helpers for the BGGR 2x2 streaming demosaicer.
package bayer_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Colour site of the current sample within the BGGR tile
    typedef enum logic [1:0] {
        POS_R,
        POS_GR,
        POS_GB,
        POS_B
    } bayer_pos_e;

    function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8:1];
    endfunction

    function automatic bayer_pos_e pos_of(input logic row_odd, input logic col_odd);
        bayer_pos_e pos;
        unique case ({row_odd, col_odd})
            2'b11:   pos = POS_R;
            2'b10:   pos = POS_GR;
            2'b01:   pos = POS_GB;
            default: pos = POS_B;
        endcase
        return pos;
    endfunction

endpackage

// File: rtl/bayer_demosaic_stream_if.sv
// Bayer sample stream in, RGB888 pixel stream out, both tagged with a linear address.
interface bayer_demosaic_stream_if #(
    parameter int unsigned ADDR_W = 19
);
    logic [7:0]        raw_bayer;
    logic              dv;
    logic [ADDR_W-1:0] w_addr;
    logic [23:0]       rgb;
    logic              out_dv;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output raw_bayer, dv, w_addr,
        input  rgb, out_dv, out_addr
    );

    modport slave (
        input  raw_bayer, dv, w_addr,
        output rgb, out_dv, out_addr
    );
endinterface

// File: rtl/bayer_line_buffer.sv
// One-line sample store: synchronous read-before-write on a single address, no reset.
module bayer_line_buffer #(
    parameter int unsigned WIDTH = 640,
    parameter int unsigned AW    = $clog2(WIDTH)
) (
    input  logic          i_clk,
    input  logic          i_en,
    input  logic [AW-1:0] i_addr,
    input  logic [7:0]    i_wdata,
    output logic [7:0]    o_rdata
);
    logic [7:0] r_mem [WIDTH];
    logic [7:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            r_rdata        <= r_mem[i_addr];
            r_mem[i_addr]  <= i_wdata;
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/bayer_demosaic_stream.sv
// Streaming BGGR demosaicer: 2x2 window from one line buffer, two-stage pipeline,
// one RGB888 output per accepted Bayer sample.
module bayer_demosaic_stream
    import bayer_pkg::*;
#(
    parameter int unsigned RESOLUTION_WIDTH  = 640,
    parameter int unsigned RESOLUTION_HEIGHT = 480,
    parameter int unsigned ADDR_W            = $clog2(RESOLUTION_WIDTH * RESOLUTION_HEIGHT)
) (
    input logic                    PCLK,
    input logic                    RST,
    bayer_demosaic_stream_if.slave bus
);
    localparam int unsigned COL_W = $clog2(RESOLUTION_WIDTH);
    localparam int unsigned ROW_W = $clog2(RESOLUTION_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(RESOLUTION_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(RESOLUTION_HEIGHT - 1);

    // Position of the next expected sample
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic              w_resync;
    logic [COL_W-1:0]  w_col_cur;
    logic [COL_W-1:0]  w_col_nxt;
    logic [ROW_W-1:0]  w_row_cur;
    logic [ROW_W-1:0]  w_row_nxt;

    logic              r_s1_valid;
    logic [7:0]        r_s1_pix;
    logic [ADDR_W-1:0] r_s1_addr;
    logic              r_s1_edge;
    bayer_pos_e        r_s1_pos;
    logic [7:0]        w_up;

    logic [7:0]        r_left;
    logic [7:0]        r_upleft;
    rgb888_t           w_pix;
    rgb888_t           r_rgb;
    logic              r_out_dv;
    logic [ADDR_W-1:0] r_out_addr;

    always_comb begin
        w_resync  = (bus.w_addr == '0);
        w_col_cur = w_resync ? '0 : r_col;
        w_row_cur = w_resync ? '0 : r_row;
        w_col_nxt = w_col_cur + COL_W'(1);
        w_row_nxt = w_row_cur;
        if (w_col_cur == COL_LAST) begin
            w_col_nxt = '0;
            w_row_nxt = (w_row_cur == ROW_LAST) ? '0 : w_row_cur + ROW_W'(1);
        end
    end

    always_ff @(posedge PCLK or posedge RST) begin
        if (RST) begin
            r_col <= '0;
            r_row <= '0;
        end else if (bus.dv) begin
            r_col <= w_col_nxt;
            r_row <= w_row_nxt;
        end
    end

    bayer_line_buffer #(
        .WIDTH (RESOLUTION_WIDTH),
        .AW    (COL_W)
    ) u_line_buffer (
        .i_clk   (PCLK),
        .i_en    (bus.dv),
        .i_addr  (w_col_cur),
        .i_wdata (bus.raw_bayer),
        .o_rdata (w_up)
    );

    always_ff @(posedge PCLK or posedge RST) begin
        if (RST) begin
            r_s1_valid <= 1'b0;
            r_s1_pix   <= '0;
            r_s1_addr  <= '0;
            r_s1_edge  <= 1'b1;
            r_s1_pos   <= POS_B;
        end else begin
            r_s1_valid <= bus.dv;
            if (bus.dv) begin
                r_s1_pix  <= bus.raw_bayer;
                r_s1_addr <= bus.w_addr;
                r_s1_edge <= (w_row_cur == '0) || (w_col_cur == '0);
                r_s1_pos  <= pos_of(w_row_cur[0], w_col_cur[0]);
            end
        end
    end

    always_comb begin
        w_pix = '0;
        unique case (r_s1_pos)
            POS_R: begin
                w_pix.r = r_s1_pix;
                w_pix.g = avg8(r_left, w_up);
                w_pix.b = r_upleft;
            end
            POS_GR: begin
                w_pix.r = r_left;
                w_pix.g = avg8(r_s1_pix, r_upleft);
                w_pix.b = w_up;
            end
            POS_GB: begin
                w_pix.r = w_up;
                w_pix.g = avg8(r_s1_pix, r_upleft);
                w_pix.b = r_left;
            end
            POS_B: begin
                w_pix.r = r_upleft;
                w_pix.g = avg8(r_left, w_up);
                w_pix.b = r_s1_pix;
            end
            default: w_pix = '0;
        endcase
        // First row/column has no full window; blank it so stale buffer data never escapes
        if (r_s1_edge) begin
            w_pix = '0;
        end
    end

    // Window history advances only on valid samples so dv gaps leave it intact
    always_ff @(posedge PCLK or posedge RST) begin
        if (RST) begin
            r_left     <= '0;
            r_upleft   <= '0;
            r_rgb      <= '0;
            r_out_dv   <= 1'b0;
            r_out_addr <= '0;
        end else begin
            r_out_dv <= r_s1_valid;
            if (r_s1_valid) begin
                r_left     <= r_s1_pix;
                r_upleft   <= w_up;
                r_rgb      <= w_pix;
                r_out_addr <= r_s1_addr;
            end
        end
    end

    assign bus.rgb      = r_rgb;
    assign bus.out_dv   = r_out_dv;
    assign bus.out_addr = r_out_addr;
endmodule

// File: tb/tb_bayer_demosaic_stream.sv
// Directed and small random-frame checks of the 4x4 demosaicer configuration.
module tb_bayer_demosaic_stream;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 4;
    localparam int unsigned AW = 4;

    typedef struct {
        logic [AW-1:0] a;
        logic [23:0]   rgb;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     n_checks = 0;
    int     n_err = 0;
    int     n_in = 0;
    int     n_out = 0;
    logic   pipe1 = 1'b0;
    logic   pipe2 = 1'b0;
    exp_t   exp_q[$];
    logic [7:0] img [H][W];

    bayer_demosaic_stream_if #(.ADDR_W(AW)) bus ();

    bayer_demosaic_stream #(
        .RESOLUTION_WIDTH  (W),
        .RESOLUTION_HEIGHT (H),
        .ADDR_W            (AW)
    ) dut (
        .PCLK (clk),
        .RST  (rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] px(input int r, input int g, input int b);
        logic [23:0] v;
        v = {8'(r), 8'(g), 8'(b)};
        return v;
    endfunction

    // Window taken straight from the stored image, independent of any buffering
    function automatic logic [23:0] model(input int r, input int c);
        int cur, up, left, ul;
        if (r == 0 || c == 0) return 24'd0;
        cur  = img[r][c];
        up   = img[r-1][c];
        left = img[r][c-1];
        ul   = img[r-1][c-1];
        if (r % 2 == 1 && c % 2 == 1) return px(cur, (left + up) / 2, ul);
        if (r % 2 == 1)               return px(left, (cur + ul) / 2, up);
        if (c % 2 == 1)               return px(up, (cur + ul) / 2, left);
        return px(ul, (left + up) / 2, cur);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic step();
        logic w;
        exp_t e;
        w = bus.dv;
        @(posedge clk);
        #1;
        pipe2 = pipe1;
        pipe1 = w;
        if (bus.out_dv === 1'b1) n_out++;
        check("out_dv", 32'(bus.out_dv), 32'(pipe2));
        if (pipe2 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_addr", 32'(bus.out_addr), 32'(e.a));
            check("rgb", 32'(bus.rgb), 32'(e.rgb));
        end
    endtask

    task automatic feed(input logic [7:0] p, input logic [AW-1:0] a, input logic [23:0] e);
        exp_t x;
        x.a   = a;
        x.rgb = e;
        exp_q.push_back(x);
        bus.dv        = 1'b1;
        bus.raw_bayer = p;
        bus.w_addr    = a;
        n_in++;
        step();
    endtask

    task automatic idle(input int n);
        bus.dv = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        bus.dv        = 1'b0;
        bus.raw_bayer = '0;
        bus.w_addr    = '0;
        step();
        check("reset out_dv", 32'(bus.out_dv), 32'd0);
        check("reset rgb", 32'(bus.rgb), 32'd0);
        check("reset out_addr", 32'(bus.out_addr), 32'd0);
        rst = 1'b0;

        // Rows 0 and 1 continuous, then row 2
        feed(8'd10, 4'd0, 24'd0);
        feed(8'd20, 4'd1, 24'd0);
        feed(8'd30, 4'd2, 24'd0);
        feed(8'd40, 4'd3, 24'd0);
        feed(8'd50, 4'd4, 24'd0);
        feed(8'd60, 4'd5, px(60, 35, 10));
        feed(8'd70, 4'd6, px(60, 45, 30));
        feed(8'd80, 4'd7, px(80, 55, 30));
        feed(8'd90, 4'd8, 24'd0);
        feed(8'd100, 4'd9, px(60, 75, 90));
        feed(8'd110, 4'd10, px(60, 85, 110));
        feed(8'd120, 4'd11, px(80, 95, 110));
        idle(2);

        // Same rows with a 3-cycle dv gap between addr5 and addr6
        feed(8'd10, 4'd0, 24'd0);
        feed(8'd20, 4'd1, 24'd0);
        feed(8'd30, 4'd2, 24'd0);
        feed(8'd40, 4'd3, 24'd0);
        feed(8'd50, 4'd4, 24'd0);
        feed(8'd60, 4'd5, px(60, 35, 10));
        idle(3);
        check("gap hold rgb", 32'(bus.rgb), 32'(px(60, 35, 10)));
        check("gap hold addr", 32'(bus.out_addr), 32'd5);
        feed(8'd70, 4'd6, px(60, 45, 30));
        feed(8'd80, 4'd7, px(80, 55, 30));
        idle(2);

        // Resync mid-frame, just after the start of row 2
        feed(8'd90, 4'd8, 24'd0);
        feed(8'd100, 4'd9, px(60, 75, 90));
        feed(8'd11, 4'd0, 24'd0);
        feed(8'd22, 4'd1, 24'd0);
        feed(8'd33, 4'd2, 24'd0);
        feed(8'd44, 4'd3, 24'd0);
        feed(8'd55, 4'd4, 24'd0);
        feed(8'd66, 4'd5, px(66, 38, 11));
        feed(8'd77, 4'd6, px(66, 49, 33));
        feed(8'd88, 4'd7, 24'd0);

        // Asynchronous reset while out_dv is high
        check("pre-reset out_dv", 32'(bus.out_dv), 32'd1);
        rst    = 1'b1;
        bus.dv = 1'b0;
        #1;
        check("async rst out_dv", 32'(bus.out_dv), 32'd0);
        check("async rst rgb", 32'(bus.rgb), 32'd0);
        check("async rst out_addr", 32'(bus.out_addr), 32'd0);
        exp_q.delete();
        pipe1 = 1'b0;
        pipe2 = 1'b0;
        n_in  = 0;
        n_out = 0;
        step();
        rst = 1'b0;
        feed(8'd200, 4'd9, 24'd0);
        feed(8'd201, 4'd10, 24'd0);
        idle(2);

        // Two random frames against the image-based model
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < int'(H); r++)
                for (int c = 0; c < int'(W); c++)
                    img[r][c] = 8'($urandom_range(0, 255));
            for (int r = 0; r < int'(H); r++)
                for (int c = 0; c < int'(W); c++)
                    feed(img[r][c], AW'(r * int'(W) + c), model(r, c));
        end
        idle(3);
        check("out_dv count", 32'(n_out), 32'(n_in));
        check("queue drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
